// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch/decode constants, IF/ID payload and fetch FSM encoding.
package if_stage_pkg;

   localparam logic [3:0]  OPC_HLT   = 4'hF;
   localparam logic [15:0] INSTR_NOP = 16'h0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic        valid;
   } if_id_t;

   function automatic logic [3:0] opcode(input logic [15:0] instr);
      return instr[15:12];
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: control, instruction-memory and IF/ID signals of the fetch stage.
interface if_stage_if;

   logic        stall;
   logic        flush;
   logic [15:0] redirect_pc;
   logic [15:0] instr_in;
   logic [15:0] iaddr;
   logic [15:0] instr_ID;
   logic [15:0] pc_ID;
   logic        valid_ID;
   logic        fetch_halted;

   modport master (
      input  stall, flush, redirect_pc, instr_in,
      output iaddr, instr_ID, pc_ID, valid_ID, fetch_halted
   );

   modport slave (
      output stall, flush, redirect_pc, instr_in,
      input  iaddr, instr_ID, pc_ID, valid_ID, fetch_halted
   );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble overrides hold, a bubble keeps the old pc.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = INSTR_NOP
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   hold,
   input  logic   bubble,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q <= '{instr: NOP_INSTR, pc: 16'h0000, valid: 1'b0};
      end else if (bubble) begin
         q.instr <= NOP_INSTR;
         q.valid <= 1'b0;
      end else if (!hold) begin
         q <= d;
      end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, fetch RUN/HALT FSM and IF/ID register.
// Priority per edge: rst > flush > stall > normal fetch.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = OPC_HLT,
   parameter logic [15:0] NOP_INSTR  = INSTR_NOP
) (
   input  logic            clk,
   input  logic            rst,
   if_stage_if.master      bus
);

   fetch_state_e state, state_nxt;
   logic [15:0]  pc, pc_nxt, pc_inc;
   logic         is_hlt;
   if_id_t       id_d, id_q;

   assign pc_inc = pc + 16'h0001;
   assign is_hlt = opcode(bus.instr_in) == HLT_OPCODE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= RUN;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end

   // A flush always returns to RUN, even when the redirecting fetch sees an HLT.
   always_comb begin
      state_nxt = bus.flush ? RUN :
                  bus.stall ? state :
                  (state == RUN && is_hlt) ? HALT : state;
      pc_nxt    = bus.flush ? bus.redirect_pc :
                  (bus.stall || state == HALT || is_hlt) ? pc : pc_inc;
   end

   always_comb begin
      bus.iaddr        = pc;
      bus.fetch_halted = state == HALT;
      bus.instr_ID     = id_q.instr;
      bus.pc_ID        = id_q.pc;
      bus.valid_ID     = id_q.valid;
   end

   assign id_d = '{instr: bus.instr_in, pc: pc_inc, valid: 1'b1};

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk    (clk),
      .rst    (rst),
      .hold   (bus.stall),
      .bubble (bus.flush | (!bus.stall & state == HALT)),
      .d      (id_d),
      .q      (id_q)
   );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stall, flush, halt, wrap and async reset.
module tb_if_stage;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic [15:0] imem [65536];
   logic [49:0] obs;

   always #5 clk = ~clk;

   if_stage_if bus();

   if_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.instr_in = imem[bus.iaddr];
   assign obs = {bus.iaddr, bus.instr_ID, bus.pc_ID, bus.valid_ID, bus.fetch_halted};

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++;
      if (obs !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset got %h want %h", obs, {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0});
      end
      rst = 1'b0;
   endtask

   task automatic test_run();
      logic [49:0] exp [5];
      exp[0] = {16'h0001, 16'h1123, 16'h0001, 1'b1, 1'b0};
      exp[1] = {16'h0002, 16'h2456, 16'h0002, 1'b1, 1'b0};
      exp[2] = {16'h0003, 16'h3789, 16'h0003, 1'b1, 1'b0};
      exp[3] = {16'h0004, 16'h1003, 16'h0004, 1'b1, 1'b0};
      exp[4] = {16'h0005, 16'h1004, 16'h0005, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (obs !== exp[i]) begin
            bad++;
            $display("FAIL run[%0d] got %h want %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_stall();
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (obs !== {16'h0005, 16'h1004, 16'h0005, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL stall[%0d] got %h want %h", i, obs, {16'h0005, 16'h1004, 16'h0005, 1'b1, 1'b0});
         end
      end
      bus.stall = 1'b0;
      tick();
      total++;
      if (obs !== {16'h0006, 16'h1005, 16'h0006, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL stall_resume got %h want %h", obs, {16'h0006, 16'h1005, 16'h0006, 1'b1, 1'b0});
      end
   endtask

   task automatic test_flush();
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      bus.redirect_pc = 16'h0040;
      tick();
      total++;
      if (obs !== {16'h0040, 16'h0000, 16'h0006, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL flush got %h want %h", obs, {16'h0040, 16'h0000, 16'h0006, 1'b0, 1'b0});
      end
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      tick();
      total++;
      if (obs !== {16'h0041, 16'h1040, 16'h0041, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL flush_target got %h want %h", obs, {16'h0041, 16'h1040, 16'h0041, 1'b1, 1'b0});
      end
   endtask

   task automatic test_halt();
      bus.flush = 1'b1;
      bus.redirect_pc = 16'h0008;
      tick();
      bus.flush = 1'b0;
      tick();
      total++;
      if (obs !== {16'h0008, 16'hF000, 16'h0009, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL halt_enter got %h want %h", obs, {16'h0008, 16'hF000, 16'h0009, 1'b1, 1'b1});
      end
      for (int i = 0; i < 6; i++) begin
         bus.stall = (i == 5);
         tick();
         total++;
         if (obs !== {16'h0008, 16'h0000, 16'h0009, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL halt_bubble[%0d] got %h want %h", i, obs, {16'h0008, 16'h0000, 16'h0009, 1'b0, 1'b1});
         end
      end
      bus.stall = 1'b0;
   endtask

   task automatic test_halt_redirect();
      bus.flush = 1'b1;
      bus.redirect_pc = 16'h0020;
      tick();
      total++;
      if (obs !== {16'h0020, 16'h0000, 16'h0009, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL halt_flush got %h want %h", obs, {16'h0020, 16'h0000, 16'h0009, 1'b0, 1'b0});
      end
      bus.flush = 1'b0;
      tick();
      total++;
      if (obs !== {16'h0021, 16'h1020, 16'h0021, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL halt_resume got %h want %h", obs, {16'h0021, 16'h1020, 16'h0021, 1'b1, 1'b0});
      end
   endtask

   task automatic test_wrap();
      bus.flush = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      tick();
      bus.flush = 1'b0;
      total++;
      if (obs !== {16'hFFFF, 16'h0000, 16'h0021, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL wrap_redirect got %h want %h", obs, {16'hFFFF, 16'h0000, 16'h0021, 1'b0, 1'b0});
      end
      tick();
      total++;
      if (obs !== {16'h0000, 16'h1FFF, 16'h0000, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL wrap got %h want %h", obs, {16'h0000, 16'h1FFF, 16'h0000, 1'b1, 1'b0});
      end
      tick();
      total++;
      if (obs !== {16'h0001, 16'h1123, 16'h0001, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL wrap_next got %h want %h", obs, {16'h0001, 16'h1123, 16'h0001, 1'b1, 1'b0});
      end
   endtask

   task automatic test_async_reset();
      bus.flush = 1'b1;
      bus.redirect_pc = 16'h0008;
      tick();
      bus.flush = 1'b0;
      tick();
      total++;
      if (obs !== {16'h0008, 16'hF000, 16'h0009, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL pre_reset_halt got %h want %h", obs, {16'h0008, 16'hF000, 16'h0009, 1'b1, 1'b1});
      end
      #1 rst = 1'b1;
      #1;
      total++;
      if (obs !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL async_reset got %h want %h", obs, {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0});
      end
      tick();
      rst = 1'b0;
      tick();
      total++;
      if (obs !== {16'h0001, 16'h1123, 16'h0001, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL post_reset_run got %h want %h", obs, {16'h0001, 16'h1123, 16'h0001, 1'b1, 1'b0});
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.redirect_pc = 16'h0000;
      for (int a = 0; a < 65536; a++) imem[a] = {4'h1, a[11:0]};
      imem[0] = 16'h1123;
      imem[1] = 16'h2456;
      imem[2] = 16'h3789;
      imem[8] = 16'hF000;
      test_reset();
      test_run();
      test_stall();
      test_flush();
      test_halt();
      test_halt_redirect();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
